// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the serializer front end and the serial sequence-detector FSMs.
// Holds the serializer state encoding and the default idle line level.
package seq_fsm_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StPar   = 2'b10
    } ser_state_e;

    // Line level between frames; a marking-high line keeps detectors from seeing stray zeros.
    localparam logic IdleBitDefault = 1'b1;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register used by bit_serializer.
// Exposes the head bit of the incoming word and the bit following the current head.
module piso_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             first_o,
    output logic             next_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // The head of the register is already on the line, so the caller needs the bit after it.
    assign first_o = MSB_FIRST ? data_i[WIDTH-1] : data_i[0];
    assign next_o  = MSB_FIRST ? sr_q[WIDTH-2]   : sr_q[1];

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end feeding the serial sequence detectors over valid/ready.
// Define PARITY_EN to append one even-parity bit to every frame.
module bit_serializer
    import seq_fsm_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = IdleBitDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    output logic             sout_o,
    output logic             sout_valid_o,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    ser_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sout_q, sout_d;
    logic            sout_valid_q, sout_valid_d;

    logic            xfer;
    logic            last_bit;
    logic            end_frame;
    logic            load;
    logic            shift;
    logic            first_bit;
    logic            next_bit;

`ifdef PARITY_EN
    logic            parity_q;
`endif

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (din_i),
        .first_o (first_bit),
        .next_o  (next_bit)
    );

    assign xfer     = din_valid_i & din_ready_o;
    assign last_bit = (cnt_q == CntLast);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            sout_q       <= IDLE_BIT;
            sout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^din_i;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sout_d    = sout_q;
        load      = 1'b0;
        shift     = 1'b0;
        end_frame = 1'b0;

        case (state_q)
            StIdle: begin
                end_frame = 1'b1;
            end
            StShift: begin
                if (!last_bit) begin
                    shift  = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    sout_d = next_bit;
                end else begin
`ifdef PARITY_EN
                    state_d = StPar;
                    cnt_d   = '0;
                    sout_d  = parity_q;
`else
                    end_frame = 1'b1;
`endif
                end
            end
`ifdef PARITY_EN
            StPar: begin
                end_frame = 1'b1;
            end
`endif
            default: begin
                end_frame = 1'b1;
            end
        endcase

        // Either start the next word with no gap or drop the line back to idle.
        if (end_frame) begin
            cnt_d = '0;
            if (xfer) begin
                load    = 1'b1;
                state_d = StShift;
                sout_d  = first_bit;
            end else begin
                state_d = StIdle;
                sout_d  = IDLE_BIT;
            end
        end

        sout_valid_d = (state_d != StIdle);
    end

    // Output logic
    always_comb begin
        din_ready_o  = 1'b0;
        frame_done_o = 1'b0;
        case (state_q)
            StIdle: begin
                din_ready_o = 1'b1;
            end
            StShift: begin
`ifdef PARITY_EN
                din_ready_o  = 1'b0;
                frame_done_o = 1'b0;
`else
                din_ready_o  = last_bit;
                frame_done_o = last_bit;
`endif
            end
`ifdef PARITY_EN
            StPar: begin
                din_ready_o  = 1'b1;
                frame_done_o = 1'b1;
            end
`endif
            default: begin
                din_ready_o = 1'b0;
            end
        endcase
        if (rst) begin
            din_ready_o = 1'b0;
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign sout_o       = sout_q;
    assign sout_valid_o = sout_valid_q;

endmodule
